// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU board I/O blocks.
// Switch debounce state encoding and default settle time.
package cpu_io_pkg;

    typedef enum logic {
        DB_IDLE,
        DB_COUNT
    } db_state_t;

    localparam int WORD_W_DFLT    = 8;
    localparam int DB_CYCLES_DFLT = 4;

endpackage

// File: rtl/switch_debounce_if.sv
// Board switch levels in, debounced levels and edge pulses out.
interface switch_debounce_if #(
    parameter int WORD_W = 8
);

    logic [WORD_W-1:0] sw_raw;
    logic [WORD_W-1:0] switches;
    logic              changed;
    logic [WORD_W-1:0] change_msk;
    logic [WORD_W-1:0] rise;

    modport master (
        output sw_raw,
        input  switches,
        input  changed,
        input  change_msk,
        input  rise
    );

    modport slave (
        input  sw_raw,
        output switches,
        output changed,
        output change_msk,
        output rise
    );

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: commits the synchronised level once it has
// disagreed with the stable level for DB_CYCLES straight cycles.
module debounce_bit
    import cpu_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DFLT
) (
    input  logic clock,
    input  logic reset,
    input  logic in_sync,
    output logic stable,
    output logic commit,
    output logic rise
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    db_state_t        state;
    db_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             stable_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DB_IDLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            stable <= stable_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        stable_nx = stable;
        commit    = 1'b0;
        rise      = 1'b0;
        unique case (state)
            DB_IDLE: begin
                if (in_sync != stable) begin
                    state_nx = DB_COUNT;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            DB_COUNT: begin
                if (in_sync == stable) begin
                    state_nx = DB_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx  = DB_IDLE;
                    cnt_nx    = '0;
                    stable_nx = in_sync;
                    commit    = 1'b1;
                    rise      = in_sync;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = DB_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/switch_debounce.sv
// Slide switch conditioner: 2-FF synchroniser, per-bit debounce,
// and registered one-cycle change/rise pulses for the CPU.
module switch_debounce
    import cpu_io_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DFLT,
    parameter int DB_CYCLES = DB_CYCLES_DFLT
) (
    input  logic              clock,
    input  logic              reset,
    switch_debounce_if.slave  io
);

    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] s2;
    logic [WORD_W-1:0] stable;
    logic [WORD_W-1:0] commit;
    logic [WORD_W-1:0] rise_nx;
    logic [WORD_W-1:0] change_msk_q;
    logic [WORD_W-1:0] rise_q;
    logic              changed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= io.sw_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WORD_W; i++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_bit (
            .clock   (clock),
            .reset   (reset),
            .in_sync (s2[i]),
            .stable  (stable[i]),
            .commit  (commit[i]),
            .rise    (rise_nx[i])
        );
    end

    // Pulses register on the commit edge, so they line up with the new level.
    always_ff @(posedge clock) begin
        if (reset) begin
            change_msk_q <= '0;
            rise_q       <= '0;
            changed_q    <= 1'b0;
        end else begin
            change_msk_q <= commit;
            rise_q       <= rise_nx;
            changed_q    <= |commit;
        end
    end

    assign io.switches   = stable;
    assign io.change_msk = change_msk_q;
    assign io.rise       = rise_q;
    assign io.changed    = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed table, corner sequences,
// and random switch activity against a sliding-window model.
module tb_switch_debounce;

    localparam int W  = 8;
    localparam int DB = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    switch_debounce_if #(.WORD_W(W)) io ();

    switch_debounce #(
        .WORD_W    (W),
        .DB_CYCLES (DB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a bit commits when its last DB sampled levels
    // all differ from the current stable level.
    logic [W-1:0] m_s1, m_s2, m_sw, m_msk, m_rise;
    logic [W-1:0] hist[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [W-1:0] raw);
        logic [W-1:0] cm;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0;
            m_msk = '0; m_rise = '0;
            hist = {};
            repeat (DB) hist.push_back('0);
        end else begin
            hist.push_back(m_s2);
            void'(hist.pop_front());
            cm = '1;
            foreach (hist[j]) cm &= hist[j] ^ m_sw;
            m_rise = cm & m_s2;
            m_sw   = m_sw ^ cm;
            m_msk  = cm;
            m_s2   = m_s1;
            m_s1   = raw;
        end
    endtask

    task automatic step(input logic rst, input logic [W-1:0] raw);
        @(negedge clock);
        reset     = rst;
        io.sw_raw = raw;
        @(posedge clock);
        model_edge(rst, raw);
        #1;
        check("model_switches", 32'(io.switches), 32'(m_sw));
        check("model_changed", 32'(io.changed), 32'(|m_msk));
        check("model_msk", 32'(io.change_msk), 32'(m_msk));
        check("model_rise", 32'(io.rise), 32'(m_rise));
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] raw;
        logic [W-1:0] sw;
        logic         chg;
        logic [W-1:0] msk;
        logic [W-1:0] rise;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input int n, input logic rst,
                                input logic [W-1:0] raw, input logic [W-1:0] sw,
                                input logic chg, input logic [W-1:0] msk,
                                input logic [W-1:0] rise);
        vec_t v;
        v.rst = rst; v.raw = raw; v.sw = sw;
        v.chg = chg; v.msk = msk; v.rise = rise;
        repeat (n) tv.push_back(v);
    endfunction

    logic [W-1:0] seen_msk;
    logic [W-1:0] seen_rise;
    logic         seen_chg;
    logic [W-1:0] raw;

    initial begin
        reset     = 1'b1;
        io.sw_raw = '0;

        // reset with FF held, release, commit on 6th edge after capture start
        add(2, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
        add(5, 0, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
        add(1, 0, 8'hFF, 8'hFF, 1, 8'hFF, 8'hFF);
        add(1, 0, 8'hFF, 8'hFF, 0, 8'h00, 8'h00);
        // all bits fall
        add(5, 0, 8'h00, 8'hFF, 0, 8'h00, 8'h00);
        add(1, 0, 8'h00, 8'h00, 1, 8'hFF, 8'h00);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        // clean rising bit 0
        add(5, 0, 8'h01, 8'h00, 0, 8'h00, 8'h00);
        add(1, 0, 8'h01, 8'h01, 1, 8'h01, 8'h01);
        add(1, 0, 8'h01, 8'h01, 0, 8'h00, 8'h00);
        // falling bit 0
        add(5, 0, 8'h00, 8'h01, 0, 8'h00, 8'h00);
        add(1, 0, 8'h00, 8'h00, 1, 8'h01, 8'h00);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);

        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].raw);
            check($sformatf("tv%0d_sw", i), 32'(io.switches), 32'(tv[i].sw));
            check($sformatf("tv%0d_chg", i), 32'(io.changed), 32'(tv[i].chg));
            check($sformatf("tv%0d_msk", i), 32'(io.change_msk), 32'(tv[i].msk));
            check($sformatf("tv%0d_rise", i), 32'(io.rise), 32'(tv[i].rise));
        end

        // 3-cycle glitch is rejected
        seen_chg = 1'b0;
        repeat (3) begin step(0, 8'h01); seen_chg |= io.changed; end
        repeat (8) begin step(0, 8'h00); seen_chg |= io.changed; end
        check("glitch3_changed", 32'(seen_chg), 32'(0));
        check("glitch3_sw", 32'(io.switches), 32'(0));

        // 4-cycle pulse commits once up, then back down
        seen_rise = '0;
        seen_chg  = 1'b0;
        repeat (4) begin step(0, 8'h01); seen_rise |= io.rise; end
        repeat (8) begin
            step(0, 8'h00);
            seen_rise |= io.rise;
            seen_chg  |= io.changed;
        end
        check("pulse4_rise", 32'(seen_rise), 32'(8'h01));
        check("pulse4_changed", 32'(seen_chg), 32'(1));

        // bits 3 and 7 together: one pulse
        for (int i = 1; i <= 7; i++) begin
            step(0, 8'h88);
            if (i == 6) begin
                check("simul_msk", 32'(io.change_msk), 32'(8'h88));
                check("simul_chg", 32'(io.changed), 32'(1));
            end
            if (i == 7) check("simul_clear", 32'(io.change_msk), 32'(0));
        end

        // bit 3 falls on time while bit 5 chatters
        seen_msk = '0;
        for (int i = 1; i <= 8; i++) begin
            raw = (i % 2) ? 8'hA0 : 8'h80;
            step(0, raw);
            seen_msk |= io.change_msk;
            if (i == 6) check("indep_msk", 32'(io.change_msk), 32'(8'h08));
        end
        check("indep_bit5", 32'(seen_msk[5]), 32'(0));

        // reset mid-count drops state and leaves no stale pulse
        repeat (8) step(0, 8'hFF);
        check("pre_reset_sw", 32'(io.switches), 32'(8'hFF));
        repeat (4) step(0, 8'hFE);
        step(1, 8'hFE);
        check("midrst_sw", 32'(io.switches), 32'(0));
        check("midrst_chg", 32'(io.changed), 32'(0));
        seen_chg = 1'b0;
        repeat (8) begin step(0, 8'h00); seen_chg |= io.changed; end
        check("post_rst_quiet", 32'(seen_chg), 32'(0));

        // random switch activity with occasional resets
        raw = '0;
        for (int i = 0; i < 600; i++) begin
            raw ^= W'($urandom & $urandom & $urandom);
            step($urandom_range(0, 99) == 0, raw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
